// File: rtl/echo_responder_pkg.sv
// Shared types and legal parameter ranges for the echo responder.
package echo_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAUSE = 2'd1,
      SEND  = 2'd2
   } state_t;

   localparam int SEQ_W      = 8;
   localparam int DELAY_MIN  = 0;
   localparam int DELAY_MAX  = 255;
   localparam int REPEAT_MIN = 1;
   localparam int REPEAT_MAX = 256;

   function automatic bit in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/echo_responder_if.sv
// Upstream FIFO first/deq methods plus the heard indication, bundled as one port.
interface echo_responder_if #(
   parameter int DATA_WIDTH = 32
);
   import echo_responder_pkg::*;

   logic [DATA_WIDTH-1:0] in_first;
   logic                  in_first__RDY;
   logic                  in_deq__RDY;
   logic                  in_deq__ENA;
   logic                  ind_heard__RDY;
   logic                  ind_heard__ENA;
   logic [DATA_WIDTH-1:0] ind_heard_v;
   logic [SEQ_W-1:0]      ind_heard_seq;

   modport master (
      input  in_first, in_first__RDY, in_deq__RDY, ind_heard__RDY,
      output in_deq__ENA, ind_heard__ENA, ind_heard_v, ind_heard_seq
   );

   modport slave (
      output in_first, in_first__RDY, in_deq__RDY, ind_heard__RDY,
      input  in_deq__ENA, ind_heard__ENA, ind_heard_v, ind_heard_seq
   );
endinterface

// File: rtl/echo_responder.sv
// Pulls one word from the echo FIFO, waits DELAY cycles, replays it REPEAT
// times on the heard indication, and counts completed echoes.
module echo_responder
   import echo_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DELAY      = 0,
   parameter int REPEAT     = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 nRST,
   echo_responder_if.master     bus,
   output logic [CNT_WIDTH-1:0] echo_count,
   output logic                 busy
);

   if (!in_range(DELAY, DELAY_MIN, DELAY_MAX)) begin : g_bad_delay
      $error("echo_responder: DELAY out of range");
   end
   if (!in_range(REPEAT, REPEAT_MIN, REPEAT_MAX)) begin : g_bad_repeat
      $error("echo_responder: REPEAT out of range");
   end

   localparam logic [SEQ_W-1:0] REP_LAST = SEQ_W'(REPEAT - 1);
   // PAUSE runs from DELAY-1 down to 0, giving exactly DELAY idle cycles.
   localparam logic [SEQ_W-1:0] DLY_INIT = (DELAY > 0) ? SEQ_W'(DELAY - 1) : '0;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] held, held_nxt;
   logic [SEQ_W-1:0]      rep, rep_nxt;
   logic [SEQ_W-1:0]      dly, dly_nxt;
   logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
   logic                  deq_fire, heard_fire;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         held  <= '0;
         rep   <= '0;
         dly   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         held  <= held_nxt;
         rep   <= rep_nxt;
         dly   <= dly_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      held_nxt   = held;
      rep_nxt    = rep;
      dly_nxt    = dly;
      cnt_nxt    = cnt;
      // Strobes are held off during reset so no word is taken and then lost.
      deq_fire   = nRST && (state == IDLE) && bus.in_first__RDY && bus.in_deq__RDY;
      heard_fire = nRST && (state == SEND) && bus.ind_heard__RDY;
      unique case (state)
         IDLE: begin
            if (deq_fire) begin
               held_nxt = bus.in_first;
               rep_nxt  = '0;
               if (DELAY > 0) begin
                  dly_nxt   = DLY_INIT;
                  state_nxt = PAUSE;
               end else begin
                  state_nxt = SEND;
               end
            end
         end
         PAUSE: begin
            if (dly == '0) state_nxt = SEND;
            else           dly_nxt   = dly - 1'b1;
         end
         SEND: begin
            if (heard_fire) begin
               if (rep == REP_LAST) begin
                  cnt_nxt   = cnt + 1'b1;
                  state_nxt = IDLE;
               end else begin
                  rep_nxt = rep + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.in_deq__ENA    = deq_fire;
   assign bus.ind_heard__ENA = heard_fire;
   assign bus.ind_heard_v    = held;
   assign bus.ind_heard_seq  = rep;
   assign echo_count         = cnt;
   assign busy               = nRST && (state != IDLE);

endmodule

// File: tb/tb_echo_responder.sv
// Runs four differently configured responders against a timestamp-based echo model.
module tb_echo_responder;

   localparam int NC = 4;

   function automatic int dly_of(input int i);
      case (i) 0: return 0; 1: return 3; 2: return 2; default: return 0; endcase
   endfunction
   function automatic int rep_of(input int i);
      case (i) 0: return 1; 1: return 2; 2: return 3; default: return 256; endcase
   endfunction
   function automatic int cw_of(input int i);
      case (i) 0: return 16; 1: return 16; 2: return 4; default: return 8; endcase
   endfunction

   typedef struct {
      int          c;
      logic [31:0] v;
      logic [7:0]  s;
   } hrec_t;

   logic CLK;
   logic nRST;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   bit   chk_on = 0;
   bit   rnd = 0;

   logic        frdy [NC];
   logic        drdy [NC];
   logic        srdy [NC];
   logic [31:0] first[NC];
   logic        deq_o[NC];
   logic        ena_o[NC];
   logic        busy_o[NC];
   logic [31:0] v_o[NC];
   logic [7:0]  seq_o[NC];
   logic [15:0] cnt_o[NC];

   logic [31:0] fq[NC][$];
   int          dlog[NC][$];
   hrec_t       hlog[NC][$];

   initial CLK = 0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < NC; g++) begin : g_inst
      localparam int D  = dly_of(g);
      localparam int R  = rep_of(g);
      localparam int CW = cw_of(g);

      logic [CW-1:0] cnt_w;
      logic          busy_w;

      echo_responder_if #(.DATA_WIDTH(32)) ifc ();

      echo_responder #(
         .DATA_WIDTH(32), .DELAY(D), .REPEAT(R), .CNT_WIDTH(CW)
      ) dut (
         .CLK(CLK), .nRST(nRST), .bus(ifc.master),
         .echo_count(cnt_w), .busy(busy_w)
      );

      assign ifc.in_first       = first[g];
      assign ifc.in_first__RDY  = frdy[g];
      assign ifc.in_deq__RDY    = drdy[g];
      assign ifc.ind_heard__RDY = srdy[g];
      assign deq_o[g]  = ifc.in_deq__ENA;
      assign ena_o[g]  = ifc.ind_heard__ENA;
      assign v_o[g]    = ifc.ind_heard_v;
      assign seq_o[g]  = ifc.ind_heard_seq;
      assign busy_o[g] = busy_w;
      assign cnt_o[g]  = 16'(cnt_w);

      // Upstream FIFO: head is the queue front, popped when the DUT dequeues.
      initial forever begin
         @(posedge CLK); #1;
         frdy[g]  = (fq[g].size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
         first[g] = (fq[g].size() != 0) ? fq[g][0] : 32'h0;
         if (rnd) begin
            drdy[g] = $urandom_range(0, 3) != 0;
            srdy[g] = $urandom_range(0, 2) != 0;
         end
      end

      // Model: a held word, the cycle it was taken, and how many copies went out.
      bit          m_hold = 0;
      logic [31:0] m_word = 0;
      int          m_tdeq = 0;
      int          m_sent = 0;
      int          m_cnt  = 0;

      always @(negedge CLK) begin
         bit e_deq, e_ena;
         if (chk_on) begin
            e_deq = nRST && !m_hold && frdy[g] && drdy[g];
            e_ena = nRST && m_hold && (cyc >= m_tdeq + 1 + D) && srdy[g];
            chk($sformatf("g%0d deq", g), {31'd0, deq_o[g]}, {31'd0, e_deq});
            chk($sformatf("g%0d ena", g), {31'd0, ena_o[g]}, {31'd0, e_ena});
            chk($sformatf("g%0d busy", g), {31'd0, busy_o[g]}, {31'd0, nRST && m_hold});
            chk($sformatf("g%0d count", g), {16'd0, cnt_o[g]}, 32'(m_cnt));
            if (e_ena && ena_o[g]) begin
               chk($sformatf("g%0d v", g), v_o[g], m_word);
               chk($sformatf("g%0d seq", g), {24'd0, seq_o[g]}, 32'(m_sent));
            end
            if (deq_o[g] === 1'b1) begin
               if (fq[g].size() != 0) void'(fq[g].pop_front());
               dlog[g].push_back(cyc);
            end
            if (ena_o[g] === 1'b1) hlog[g].push_back('{cyc, v_o[g], seq_o[g]});
            if (!nRST) begin
               m_hold = 0;
               m_cnt  = 0;
            end else if (e_deq) begin
               m_hold = 1;
               m_word = first[g];
               m_tdeq = cyc;
               m_sent = 0;
            end else if (e_ena) begin
               m_sent++;
               if (m_sent == R) begin
                  m_hold = 0;
                  m_cnt  = (m_cnt + 1) % (1 << CW);
               end
            end
         end
      end
   end

   task automatic reset_dut();
      @(posedge CLK); #1 nRST = 0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1;
      for (int i = 0; i < NC; i++) begin
         hlog[i].delete();
         dlog[i].delete();
         fq[i].delete();
      end
   endtask

   task automatic all_ready();
      for (int i = 0; i < NC; i++) begin
         srdy[i] = 1;
         drdy[i] = 1;
      end
   endtask

   task automatic wait_idle(input int i, input int budget);
      int n = 0;
      while (n < budget && (fq[i].size() != 0 || busy_o[i] || deq_o[i])) begin
         @(negedge CLK);
         n++;
      end
      #1;
      chk($sformatf("g%0d idle timeout", i), {31'd0, n < budget}, 32'd1);
   endtask

   task automatic wait_deq(input int i, input int budget, output int t);
      int n = 0;
      while (n < budget && dlog[i].size() == 0) begin
         @(negedge CLK);
         n++;
      end
      #1;
      chk($sformatf("g%0d deq timeout", i), {31'd0, dlog[i].size() != 0}, 32'd1);
      t = (dlog[i].size() != 0) ? dlog[i][0] : cyc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t, base;
      nRST = 0;
      for (int i = 0; i < NC; i++) begin
         frdy[i] = 0; drdy[i] = 0; srdy[i] = 0; first[i] = 0;
      end
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      for (int i = 0; i < NC; i++) begin
         chk($sformatf("g%0d rst deq", i), {31'd0, deq_o[i]}, 32'd0);
         chk($sformatf("g%0d rst ena", i), {31'd0, ena_o[i]}, 32'd0);
         chk($sformatf("g%0d rst busy", i), {31'd0, busy_o[i]}, 32'd0);
         chk($sformatf("g%0d rst count", i), {16'd0, cnt_o[i]}, 32'd0);
         chk($sformatf("g%0d rst v", i), v_o[i], 32'd0);
         chk($sformatf("g%0d rst seq", i), {24'd0, seq_o[i]}, 32'd0);
      end
      chk_on = 1;
      @(posedge CLK); #1 nRST = 1;

      // Single word through every configuration.
      all_ready();
      for (int i = 0; i < NC; i++) fq[i].push_back(32'hDEADBEEF);
      for (int i = 0; i < NC; i++) wait_idle(i, 600);
      for (int i = 0; i < NC; i++) begin
         chk($sformatf("g%0d t1 heard n", i), 32'(hlog[i].size()), 32'(rep_of(i)));
         chk($sformatf("g%0d t1 count", i), {16'd0, cnt_o[i]}, 32'd1);
         if (hlog[i].size() == rep_of(i) && dlog[i].size() == 1) begin
            t = dlog[i][0];
            chk($sformatf("g%0d t1 first lat", i), 32'(hlog[i][0].c - t), 32'(1 + dly_of(i)));
            chk($sformatf("g%0d t1 v", i), hlog[i][0].v, 32'hDEADBEEF);
            chk($sformatf("g%0d t1 last seq", i), {24'd0, hlog[i][rep_of(i)-1].s}, 32'(rep_of(i) - 1));
         end
      end
      if (hlog[1].size() == 2 && dlog[1].size() == 1) begin
         chk("t1 d3 seq1 cycle", 32'(hlog[1][1].c - dlog[1][0]), 32'd5);
         chk("t1 d3 seq1", {24'd0, hlog[1][1].s}, 32'd1);
      end
      if (hlog[3].size() == 256) chk("t1 r256 last seq", {24'd0, hlog[3][255].s}, 32'd255);

      // Sink stalls for 5 cycles while SEND is waiting.
      reset_dut();
      all_ready();
      srdy[1] = 0;
      fq[1].push_back(32'h12345678);
      wait_deq(1, 50, t);
      while (cyc < t + 4) @(negedge CLK);
      for (int k = 0; k < 5; k++) begin
         chk("stall ena", {31'd0, ena_o[1]}, 32'd0);
         chk("stall v", v_o[1], 32'h12345678);
         chk("stall seq", {24'd0, seq_o[1]}, 32'd0);
         chk("stall count", {16'd0, cnt_o[1]}, 32'd0);
         if (k < 4) @(negedge CLK);
      end
      @(posedge CLK); #1 srdy[1] = 1;
      wait_idle(1, 50);
      chk("stall heard n", 32'(hlog[1].size()), 32'd2);
      if (hlog[1].size() == 2) begin
         chk("stall fire cycle", 32'(hlog[1][0].c - t), 32'd9);
         chk("stall seq1 cycle", 32'(hlog[1][1].c - t), 32'd10);
      end
      chk("stall count end", {16'd0, cnt_o[1]}, 32'd1);

      // Back-to-back words from a continuously full FIFO.
      reset_dut();
      all_ready();
      for (int w = 1; w <= 3; w++) begin
         fq[0].push_back(32'(w));
         fq[1].push_back(32'(w));
      end
      wait_idle(0, 100);
      wait_idle(1, 100);
      chk("b2b deq n", 32'(dlog[0].size()), 32'd3);
      chk("b2b heard n", 32'(hlog[0].size()), 32'd3);
      if (dlog[0].size() == 3 && hlog[0].size() == 3) begin
         for (int k = 0; k < 3; k++) chk("b2b order", hlog[0][k].v, 32'(k + 1));
         chk("b2b gap0", 32'(dlog[0][1] - dlog[0][0]), 32'd2);
         chk("b2b gap1", 32'(dlog[0][2] - dlog[0][1]), 32'd2);
      end
      chk("b2b count", {16'd0, cnt_o[0]}, 32'd3);
      if (dlog[1].size() == 3) chk("b2b d3r2 gap", 32'(dlog[1][1] - dlog[1][0]), 32'd6);

      // 17 words on a 4-bit counter.
      reset_dut();
      all_ready();
      for (int w = 0; w < 17; w++) fq[2].push_back(32'h100 + 32'(w));
      wait_idle(2, 1000);
      chk("wrap heard n", 32'(hlog[2].size()), 32'd51);
      chk("wrap count", {16'd0, cnt_o[2]}, 32'd1);

      // Reset while the word is still pausing.
      reset_dut();
      all_ready();
      fq[1].push_back(32'hA5A5A5A5);
      wait_deq(1, 50, t);
      @(posedge CLK); #1 nRST = 0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1;
      repeat (10) @(negedge CLK);
      #1;
      chk("pause rst heard n", 32'(hlog[1].size()), 32'd0);
      chk("pause rst count", {16'd0, cnt_o[1]}, 32'd0);
      chk("pause rst busy", {31'd0, busy_o[1]}, 32'd0);
      base = hlog[1].size();
      fq[1].push_back(32'h0BADF00D);
      wait_idle(1, 50);
      chk("post rst heard n", 32'(hlog[1].size() - base), 32'd2);
      if (hlog[1].size() == base + 2) chk("post rst v", hlog[1][base].v, 32'h0BADF00D);
      chk("post rst count", {16'd0, cnt_o[1]}, 32'd1);

      // Random traffic, ready stalls and one mid-stream reset.
      reset_dut();
      rnd = 1;
      for (int n = 0; n < 4000; n++) begin
         @(posedge CLK); #2;
         for (int i = 0; i < NC; i++)
            if (fq[i].size() < 2 && $urandom_range(0, 2) == 0) fq[i].push_back($urandom);
         if (n == 2000) nRST = 0;
         if (n == 2003) nRST = 1;
      end
      rnd = 0;
      @(posedge CLK); #2;
      all_ready();
      for (int i = 0; i < NC; i++) wait_idle(i, 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/echo_responder.md
# echo_responder

Downstream consumer of the single-entry echo FIFO. Pulls one word at a time through the FIFO's `first`/`deq` guarded methods, holds it for a configurable pause, then replays it to the indication interface one or more times with a repeat index. Maintains a wrapping count of completed echoes for software visibility. Sits between the request FIFO and the indication (response) port of the echo test design.

## Interface
Parameters:
- `DATA_WIDTH`, 32: echoed word width; matches FIFO element width.
- `DELAY`, 0: idle cycles inserted between dequeue and first indication (0..255).
- `REPEAT`, 1: indications issued per dequeued word (1..256).
- `CNT_WIDTH`, 16: width of completed-echo counter.

Ports:
- Reset is `nRST`, synchronous, active-low. Clock is `CLK`.
- `CLK`  in  1  clock.
- `nRST`  in  1  synchronous active-low reset.
- `in_first`  in  DATA_WIDTH  upstream FIFO head value.
- `in_first__RDY`  in  1  head valid.
- `in_deq__RDY`  in  1  upstream deq guard.
- `in_deq__ENA`  out  1  dequeue strobe; one cycle per word.
- `ind_heard__RDY`  in  1  indication sink ready.
- `ind_heard__ENA`  out  1  indication fire; never asserted without RDY.
- `ind_heard_v`  out  DATA_WIDTH  held word.
- `ind_heard_seq`  out  8  repeat index, 0..REPEAT-1.
- `echo_count`  out  CNT_WIDTH  completed words, wraps modulo 2^CNT_WIDTH.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, PAUSE, SEND.
- IDLE: `in_deq__ENA = in_first__RDY && in_deq__RDY` (combinational). On fire: `held <= in_first`, `rep <= 0`; go PAUSE with `dly <= DELAY-1` if DELAY>0, else SEND.
- PAUSE: `dly` decrements each cycle; at `dly==0` go SEND. No ENA outputs.
- SEND: `ind_heard__ENA = ind_heard__RDY`; `ind_heard_v = held`, `ind_heard_seq = rep`. On fire: if `rep == REPEAT-1`, `echo_count <= echo_count+1` (wrap), go IDLE; else `rep <= rep+1`, stay SEND. RDY low: hold, nothing changes.
- `in_deq__ENA` only ever in IDLE; upstream never dequeued while a word is held.
- `ind_heard_v`/`ind_heard_seq` drive held/rep in all states; meaningful only with ENA.

## Timing
- Reset: state IDLE, `held`=0, `rep`=0, `dly`=0, `echo_count`=0; all outputs 0 (`in_deq__ENA`, `ind_heard__ENA`, `busy` low) during and the cycle after reset deassertion unless IDLE guards are met.
- Deq in cycle T -> first `ind_heard__ENA` possible in cycle T+1+DELAY.
- Final indication in cycle S -> next `in_deq__ENA` possible in S+1. DELAY=0, REPEAT=1, sink always ready: 1 word per 2 cycles.
- Reset mid-PAUSE/SEND: held word dropped, no further indications, count cleared; upstream FIFO responsible for its own reset.
- `echo_count` wrap: 2^CNT_WIDTH-1 -> 0, no flag.
- Repeat counter 8 bits; REPEAT=256 ends at seq 255.

## Structure
- Package `echo_responder_pkg`: state enum (IDLE/PAUSE/SEND), seq width constant 8, DELAY/REPEAT legal-range constants.
- Single module; no sub-module needed. Parameter range checks as elaboration assertions.

## Test plan
- Reset then FIFO presents 0xDEADBEEF, DELAY=0, REPEAT=1, sink ready -> deq at T, heard v=0xDEADBEEF seq=0 at T+1, echo_count=1, busy low T+2.
- DELAY=3, REPEAT=2, word 0x12345678 -> heard seq=0 at T+4, seq=1 at T+5, no deq until T+6.
- Sink RDY low 5 cycles in SEND -> no ENA, v/seq stable, count unchanged; fires cycle RDY rises.
- FIFO full continuously with 0x1,0x2,0x3 -> deq strobes exactly every 2 cycles, heard order 1,2,3, count=3.
- CNT_WIDTH=4, 17 words -> echo_count reads 1 after wrap.
- nRST low during PAUSE with word 0xA5A5A5A5 -> no heard ever for it, count 0, IDLE; next word echoes normally.
